// File: rtl/bus_gate_arbiter_pkg.sv
// Shared types and encodings for the LC-3 bus gate arbiter.
// Gate one-hot codes match the bus tristate mux select lines.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam logic [3:0] GATE_MDR    = 4'b1000;
    localparam logic [3:0] GATE_MARMUX = 4'b0100;
    localparam logic [3:0] GATE_PC     = 4'b0010;
    localparam logic [3:0] GATE_ALU    = 4'b0001;
    localparam logic [3:0] GATE_NONE   = 4'b0000;

    localparam int IDX_ALU    = 0;
    localparam int IDX_PC     = 1;
    localparam int IDX_MARMUX = 2;
    localparam int IDX_MDR    = 3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/bus_gate_arbiter_if.sv
// Request/grant bundle between the bus drivers and the gate arbiter.
// master = requesting side, slave = arbiter side.
interface bus_gate_arbiter_if;

    logic [3:0] Req;
    logic [3:0] Gate_Sel;
    logic [1:0] Owner_Id;
    logic       Bus_Busy;
    logic [7:0] Hold_Cnt;
    logic       Timeout;

    modport master (
        output Req,
        input  Gate_Sel,
        input  Owner_Id,
        input  Bus_Busy,
        input  Hold_Cnt,
        input  Timeout
    );

    modport slave (
        input  Req,
        output Gate_Sel,
        output Owner_Id,
        output Bus_Busy,
        output Hold_Cnt,
        output Timeout
    );

endinterface

// File: rtl/bus_gate_arbiter_rr_pick4.sv
// Round-robin pick among four requesters: rotate by rr_ptr, take the
// lowest set bit, rotate the index back.
module rr_pick4 (
    input  logic [3:0] eligible,
    input  logic [1:0] rr_ptr,
    output logic [1:0] winner,
    output logic       found
);

    logic [7:0] doubled;
    logic [3:0] rotated;
    logic [1:0] offset;

    always_comb begin
        doubled = {eligible, eligible} >> rr_ptr;
        rotated = doubled[3:0];
        offset  = 2'd0;
        found   = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = 2'(i);
                found  = 1'b1;
            end
        end
        winner = offset + rr_ptr;
    end

endmodule

// File: rtl/bus_gate_arbiter.sv
// Owns the shared LC-3 bus gate: round-robin grants, one dead cycle between
// owners, and a forced release with lockout after MAX_HOLD cycles.
//
//   state | meaning
//   IDLE  | bus floats, arbitrate every cycle
//   GRANT | one driver gated onto the bus, hold counter running
//   TURN  | single dead cycle after a release, arbitrate for the next owner
module bus_gate_arbiter
    import bus_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    bus_gate_arbiter_if.slave  bus
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    arb_state_t       state_q, state_n;
    logic [3:0]       gate_q, gate_n;
    logic [1:0]       owner_q, owner_n;
    logic [7:0]       hold_q, hold_n;
    logic             timeout_q, timeout_n;
    logic [1:0]       rr_ptr_q, rr_ptr_n;
    logic [3:0]       lockout_q, lockout_n;

    logic [N_REQ-1:0] eligible;
    logic [1:0]       winner;
    logic             found;

    assign eligible = bus.Req & ~lockout_q;

    rr_pick4 u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .winner   (winner),
        .found    (found)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            gate_q    <= GATE_NONE;
            owner_q   <= 2'd0;
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
            rr_ptr_q  <= 2'd0;
            lockout_q <= 4'b0000;
        end else begin
            state_q   <= state_n;
            gate_q    <= gate_n;
            owner_q   <= owner_n;
            hold_q    <= hold_n;
            timeout_q <= timeout_n;
            rr_ptr_q  <= rr_ptr_n;
            lockout_q <= lockout_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        gate_n    = gate_q;
        owner_n   = owner_q;
        hold_n    = hold_q;
        timeout_n = 1'b0;
        rr_ptr_n  = rr_ptr_q;
        // a lockout bit is released as soon as its driver is seen idle
        lockout_n = lockout_q & bus.Req;

        case (state_q)
            IDLE, TURN: begin
                if (found) begin
                    gate_n  = onehot4(winner);
                    owner_n = winner;
                    hold_n  = 8'd1;
                    state_n = GRANT;
                end else begin
                    gate_n  = GATE_NONE;
                    hold_n  = 8'd0;
                    state_n = IDLE;
                end
            end
            GRANT: begin
                if (!bus.Req[owner_q]) begin
                    gate_n   = GATE_NONE;
                    hold_n   = 8'd0;
                    rr_ptr_n = owner_q + 2'd1;
                    state_n  = TURN;
                end else if (hold_q >= HOLD_MAX) begin
                    gate_n    = GATE_NONE;
                    hold_n    = 8'd0;
                    timeout_n = 1'b1;
                    lockout_n = lockout_n | onehot4(owner_q);
                    rr_ptr_n  = owner_q + 2'd1;
                    state_n   = TURN;
                end else begin
                    hold_n = hold_q + 8'd1;
                end
            end
            default: begin
                gate_n  = GATE_NONE;
                hold_n  = 8'd0;
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.Gate_Sel = gate_q;
        bus.Owner_Id = owner_q;
        bus.Bus_Busy = |gate_q;
        bus.Hold_Cnt = hold_q;
        bus.Timeout  = timeout_q;
    end

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed and random checks for bus_gate_arbiter with MAX_HOLD=8.
module tb_bus_gate_arbiter;

    localparam int MAX_HOLD = 8;

    logic Clk;
    logic Reset_n;
    int   n_pass;
    int   n_total;

    bus_gate_arbiter_if bus_if ();

    bus_gate_arbiter #(.N_REQ(4), .MAX_HOLD(MAX_HOLD)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Reset_n    = 1'b0;
        bus_if.Req = 4'b0000;
        tick();
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n    = 1'b0;
        bus_if.Req = 4'b1111;
        tick();
        tick();
        n_total++;
        if (bus_if.Gate_Sel !== 4'b0000 || bus_if.Owner_Id !== 2'd0 || bus_if.Bus_Busy !== 1'b0 ||
            bus_if.Hold_Cnt !== 8'd0 || bus_if.Timeout !== 1'b0)
            $display("FAIL reset: gate=%b owner=%0d busy=%b hold=%0d to=%b, want 0000/0/0/0/0",
                     bus_if.Gate_Sel, bus_if.Owner_Id, bus_if.Bus_Busy, bus_if.Hold_Cnt, bus_if.Timeout);
        else n_pass++;
        bus_if.Req = 4'b0000;
        Reset_n    = 1'b1;
        tick();
    endtask

    task automatic test_single_pc();
        apply_reset();
        bus_if.Req = 4'b0010;
        for (int h = 1; h <= 3; h++) begin
            tick();
            n_total++;
            if (bus_if.Gate_Sel !== 4'b0010 || bus_if.Hold_Cnt !== 8'(h) || bus_if.Owner_Id !== 2'd1 ||
                bus_if.Bus_Busy !== 1'b1)
                $display("FAIL pc_grant[%0d]: gate=%b hold=%0d owner=%0d busy=%b, want 0010/%0d/1/1",
                         h, bus_if.Gate_Sel, bus_if.Hold_Cnt, bus_if.Owner_Id, bus_if.Bus_Busy, h);
            else n_pass++;
        end
        bus_if.Req = 4'b0000;
        tick();
        n_total++;
        if (bus_if.Gate_Sel !== 4'b0000 || bus_if.Hold_Cnt !== 8'd0 || bus_if.Timeout !== 1'b0)
            $display("FAIL pc_turn: gate=%b hold=%0d to=%b, want 0000/0/0",
                     bus_if.Gate_Sel, bus_if.Hold_Cnt, bus_if.Timeout);
        else n_pass++;
        tick();
        n_total++;
        if (bus_if.Gate_Sel !== 4'b0000 || bus_if.Bus_Busy !== 1'b0)
            $display("FAIL pc_idle: gate=%b busy=%b, want 0000/0", bus_if.Gate_Sel, bus_if.Bus_Busy);
        else n_pass++;
        // rr_ptr=2 makes MARMUX win over PC
        bus_if.Req = 4'b0110;
        tick();
        n_total++;
        if (bus_if.Gate_Sel !== 4'b0100 || bus_if.Owner_Id !== 2'd2)
            $display("FAIL pc_rrptr: gate=%b owner=%0d, want 0100/2", bus_if.Gate_Sel, bus_if.Owner_Id);
        else n_pass++;
        bus_if.Req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gate [4];
        exp_gate = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        apply_reset();
        bus_if.Req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            for (int h = 1; h <= MAX_HOLD; h++) begin
                tick();
                n_total++;
                if (bus_if.Gate_Sel !== exp_gate[k] || bus_if.Hold_Cnt !== 8'(h) ||
                    bus_if.Owner_Id !== 2'(k) || bus_if.Timeout !== 1'b0 || bus_if.Bus_Busy !== 1'b1)
                    $display("FAIL rr_grant[%0d,%0d]: gate=%b hold=%0d owner=%0d to=%b, want %b/%0d/%0d/0",
                             k, h, bus_if.Gate_Sel, bus_if.Hold_Cnt, bus_if.Owner_Id, bus_if.Timeout,
                             exp_gate[k], h, k);
                else n_pass++;
            end
            tick();
            n_total++;
            if (bus_if.Gate_Sel !== 4'b0000 || bus_if.Timeout !== 1'b1 || bus_if.Bus_Busy !== 1'b0)
                $display("FAIL rr_timeout[%0d]: gate=%b to=%b busy=%b, want 0000/1/0",
                         k, bus_if.Gate_Sel, bus_if.Timeout, bus_if.Bus_Busy);
            else n_pass++;
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_total++;
            if (bus_if.Gate_Sel !== 4'b0000 || bus_if.Timeout !== 1'b0)
                $display("FAIL rr_all_locked[%0d]: gate=%b to=%b, want 0000/0", c, bus_if.Gate_Sel, bus_if.Timeout);
            else n_pass++;
        end
        bus_if.Req = 4'b0000;
        tick();
        bus_if.Req = 4'b1111;
        tick();
        n_total++;
        if (bus_if.Gate_Sel !== 4'b0001 || bus_if.Hold_Cnt !== 8'd1)
            $display("FAIL rr_unlock: gate=%b hold=%0d, want 0001/1", bus_if.Gate_Sel, bus_if.Hold_Cnt);
        else n_pass++;
        bus_if.Req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_timeout_lockout();
        apply_reset();
        bus_if.Req = 4'b0001;
        for (int c = 1; c <= 20; c++) begin
            tick();
            n_total++;
            if (c <= MAX_HOLD) begin
                if (bus_if.Gate_Sel !== 4'b0001 || bus_if.Hold_Cnt !== 8'(c) || bus_if.Timeout !== 1'b0)
                    $display("FAIL to_hold[%0d]: gate=%b hold=%0d to=%b, want 0001/%0d/0",
                             c, bus_if.Gate_Sel, bus_if.Hold_Cnt, bus_if.Timeout, c);
                else n_pass++;
            end else if (c == MAX_HOLD + 1) begin
                if (bus_if.Gate_Sel !== 4'b0000 || bus_if.Timeout !== 1'b1)
                    $display("FAIL to_pulse: gate=%b to=%b, want 0000/1", bus_if.Gate_Sel, bus_if.Timeout);
                else n_pass++;
            end else begin
                if (bus_if.Gate_Sel !== 4'b0000 || bus_if.Timeout !== 1'b0)
                    $display("FAIL to_locked[%0d]: gate=%b to=%b, want 0000/0",
                             c, bus_if.Gate_Sel, bus_if.Timeout);
                else n_pass++;
            end
        end
        bus_if.Req = 4'b0000;
        tick();
        n_total++;
        if (bus_if.Gate_Sel !== 4'b0000)
            $display("FAIL to_drop: gate=%b, want 0000", bus_if.Gate_Sel);
        else n_pass++;
        bus_if.Req = 4'b0001;
        tick();
        n_total++;
        if (bus_if.Gate_Sel !== 4'b0001 || bus_if.Hold_Cnt !== 8'd1)
            $display("FAIL to_regrant: gate=%b hold=%0d, want 0001/1", bus_if.Gate_Sel, bus_if.Hold_Cnt);
        else n_pass++;
        bus_if.Req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_release_at_max();
        apply_reset();
        bus_if.Req = 4'b1001;
        for (int h = 1; h <= MAX_HOLD; h++) begin
            tick();
            n_total++;
            if (bus_if.Gate_Sel !== 4'b0001 || bus_if.Hold_Cnt !== 8'(h))
                $display("FAIL edge_hold[%0d]: gate=%b hold=%0d, want 0001/%0d",
                         h, bus_if.Gate_Sel, bus_if.Hold_Cnt, h);
            else n_pass++;
        end
        bus_if.Req = 4'b1000;
        tick();
        n_total++;
        if (bus_if.Gate_Sel !== 4'b0000 || bus_if.Timeout !== 1'b0 || bus_if.Hold_Cnt !== 8'd0)
            $display("FAIL edge_turn: gate=%b to=%b hold=%0d, want 0000/0/0",
                     bus_if.Gate_Sel, bus_if.Timeout, bus_if.Hold_Cnt);
        else n_pass++;
        tick();
        n_total++;
        if (bus_if.Gate_Sel !== 4'b1000 || bus_if.Owner_Id !== 2'd3 || bus_if.Hold_Cnt !== 8'd1)
            $display("FAIL edge_mdr: gate=%b owner=%0d hold=%0d, want 1000/3/1",
                     bus_if.Gate_Sel, bus_if.Owner_Id, bus_if.Hold_Cnt);
        else n_pass++;
        bus_if.Req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus_if.Req = 4'b0100;
        tick();
        tick();
        n_total++;
        if (bus_if.Gate_Sel !== 4'b0100 || bus_if.Hold_Cnt !== 8'd2)
            $display("FAIL ar_pre: gate=%b hold=%0d, want 0100/2", bus_if.Gate_Sel, bus_if.Hold_Cnt);
        else n_pass++;
        #3;
        Reset_n = 1'b0;
        #1;
        n_total++;
        if (bus_if.Gate_Sel !== 4'b0000 || bus_if.Bus_Busy !== 1'b0 || bus_if.Hold_Cnt !== 8'd0)
            $display("FAIL ar_drop: gate=%b busy=%b hold=%0d, want 0000/0/0",
                     bus_if.Gate_Sel, bus_if.Bus_Busy, bus_if.Hold_Cnt);
        else n_pass++;
        bus_if.Req = 4'b1010;
        #2;
        Reset_n = 1'b1;
        tick();
        // rr_ptr back at 0 selects PC; a stale pointer of 3 would select MDR
        n_total++;
        if (bus_if.Gate_Sel !== 4'b0010 || bus_if.Owner_Id !== 2'd1)
            $display("FAIL ar_rrptr: gate=%b owner=%0d, want 0010/1", bus_if.Gate_Sel, bus_if.Owner_Id);
        else n_pass++;
        bus_if.Req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [3:0] req;
        logic [3:0] prev_gate;
        logic [3:0] g;
        logic [3:0] locked;
        int         cnt [4];
        int         last_owner;
        int         k;
        apply_reset();
        req        = 4'b0000;
        prev_gate  = 4'b0000;
        locked     = 4'b0000;
        last_owner = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            bus_if.Req = req;
            tick();
            g = bus_if.Gate_Sel;
            n_total++;
            if (!$onehot0(g) || bus_if.Bus_Busy !== (g != 4'b0000))
                $display("FAIL rnd_onehot[%0d]: gate=%b busy=%b, want onehot0 and busy=|gate",
                         c, g, bus_if.Bus_Busy);
            else n_pass++;
            n_total++;
            if (prev_gate != 4'b0000 && g != 4'b0000 && g != prev_gate)
                $display("FAIL rnd_dead[%0d]: gate %b -> %b, want a 0000 cycle between owners", c, prev_gate, g);
            else n_pass++;
            for (int i = 0; i < 4; i++)
                if (!req[i]) begin
                    locked[i] = 1'b0;
                    cnt[i]    = 0;
                end
            if (bus_if.Timeout === 1'b1) locked[last_owner] = 1'b1;
            if (prev_gate == 4'b0000 && g != 4'b0000) begin
                k = 0;
                for (int b = 0; b < 4; b++) if (g[b]) k = b;
                n_total++;
                if (locked[k] || bus_if.Owner_Id !== 2'(k))
                    $display("FAIL rnd_grant[%0d]: gate=%b owner=%0d locked=%b, want owner=%0d unlocked",
                             c, g, bus_if.Owner_Id, locked, k);
                else n_pass++;
                for (int i = 0; i < 4; i++)
                    if (i != k && req[i] && !locked[i]) cnt[i]++;
                cnt[k]     = 0;
                last_owner = k;
                n_total++;
                if (cnt[0] > 3 || cnt[1] > 3 || cnt[2] > 3 || cnt[3] > 3)
                    $display("FAIL rnd_fair[%0d]: waits=%0d,%0d,%0d,%0d, want each <= 3",
                             c, cnt[0], cnt[1], cnt[2], cnt[3]);
                else n_pass++;
            end
            prev_gate = g;
        end
        bus_if.Req = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        Reset_n    = 1'b0;
        bus_if.Req = 4'b0000;
        test_reset();
        test_single_pc();
        test_round_robin();
        test_timeout_lockout();
        test_release_at_max();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
